// File: rtl/chrono_ctrl.sv
// Stopwatch control: debounced start/stop and lap/reset buttons driving a
// four-state run/stop/lap sequencer and the display freeze mux.
//
//  state | meaning
//  IDLE  | counter held clear, waiting for start
//  RUN   | counter enabled, display live
//  STOP  | counter paused, display live
//  LAP   | counter enabled, display frozen on captured lap time
module chrono_ctrl #(
  parameter int FREQ = 50000000,
  parameter int DEB  = FREQ / 100
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       b_ss,
  input  logic       b_lr,
  input  logic [3:0] c0,
  input  logic [3:0] c1,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic       start,
  output logic       cl,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       lap
);

  typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

  localparam logic [19:0] DEB_TC = 20'(DEB - 1);

  // index 0 = start/stop button, index 1 = lap/reset button
  logic [1:0]  sy1, sy2, lvl, lvl_d;
  logic [19:0] cnt [2];
  logic [1:0]  raw;
  logic [1:0]  pulse;

  state_t      state, state_nx;
  logic        start_nx, cl_nx, lap_nx, cap;
  logic [15:0] lap_reg;

  assign raw   = {b_lr, b_ss};
  assign pulse = lvl & ~lvl_d;

  // level flips only after the synchronized input disagrees for DEB straight cycles
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      sy1    <= '0;
      sy2    <= '0;
      lvl    <= '0;
      lvl_d  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sy1   <= raw;
      sy2   <= sy1;
      lvl_d <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (sy2[i] != lvl[i]) begin
          if (cnt[i] == DEB_TC) begin
            lvl[i] <= sy2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 20'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // start/stop wins when both buttons fire in the same cycle
  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    case (state)
      IDLE: if (pulse[0]) state_nx = RUN;
      RUN: begin
        if (pulse[0]) begin
          state_nx = STOP;
        end else if (pulse[1]) begin
          state_nx = LAP;
          cap      = 1'b1;
        end
      end
      LAP: begin
        if (pulse[0])      state_nx = STOP;
        else if (pulse[1]) state_nx = RUN;
      end
      STOP: begin
        if (pulse[0])      state_nx = RUN;
        else if (pulse[1]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    start_nx = (state_nx == RUN) || (state_nx == LAP);
    cl_nx    = (state_nx == IDLE);
    lap_nx   = (state_nx == LAP);
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      start   <= 1'b0;
      cl      <= 1'b1;
      lap     <= 1'b0;
      lap_reg <= '0;
    end else begin
      state <= state_nx;
      start <= start_nx;
      cl    <= cl_nx;
      lap   <= lap_nx;
      if (cap) lap_reg <= {c0, c1, s0, s1};
    end
  end

  assign {d0, d1, d2, d3} = lap ? lap_reg : {c0, c1, s0, s1};

endmodule
